// File: rtl/bsg_zynq_mc_gearbox_bridge_pkg.sv
// Shared helpers for the Zynq/manycore gearbox bridge.
//   beats_f       : narrow beats per wide packet
//   occ_width_f   : width of the per-channel outbound occupancy count
//   idx_width_f   : safe counter/index width (never zero)
//   piso_state_e  : outbound serializer state
//   trace_tag_lp  : prefix on trace lines (BSG_ZYNQ_GEARBOX_TRACE_EN builds)
package bsg_zynq_gearbox_pkg;

   function automatic int unsigned beats_f(input int unsigned wide_w,
                                           input int unsigned narrow_w);
      return wide_w / narrow_w;
   endfunction

   function automatic int unsigned occ_width_f(input int unsigned els,
                                               input int unsigned beats);
      return $clog2(els * beats + beats + 1);
   endfunction

   function automatic int unsigned idx_width_f(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam string trace_tag_lp = "bsg_zynq_gearbox";

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } piso_state_e;

endpackage

// File: rtl/bsg_zynq_mc_gearbox_bridge_if.sv
// Handshake/bus bundle of the gearbox bridge.
//   slave  : the bridge side (consumes narrow_in / wide_in, produces wide_out / narrow_out)
//   master : the PL shell + endpoint side (testbench)
// Signals: in_clear_i, out_clear_i, narrow_in_{data,v}_i / narrow_in_ready_o,
//          wide_out_{data,v}_o / wide_out_yumi_i, wide_in_{data,v}_i / wide_in_ready_o,
//          narrow_out_{data,v}_o / narrow_out_yumi_i, out_occ_o.
interface bsg_zynq_mc_gearbox_bridge_if
   import bsg_zynq_gearbox_pkg::*;
#(
   parameter int unsigned narrow_width_p = 32,
   parameter int unsigned wide_width_p   = 128,
   parameter int unsigned num_in_chan_p  = 2,
   parameter int unsigned num_out_chan_p = 2,
   parameter int unsigned out_buf_els_p  = 4
);
   localparam int unsigned beats_lp     = beats_f(wide_width_p, narrow_width_p);
   localparam int unsigned occ_width_lp = occ_width_f(out_buf_els_p, beats_lp);

   logic [num_in_chan_p-1:0]                 in_clear_i;
   logic [num_out_chan_p-1:0]                out_clear_i;

   logic [num_in_chan_p*narrow_width_p-1:0]  narrow_in_data_i;
   logic [num_in_chan_p-1:0]                 narrow_in_v_i;
   logic [num_in_chan_p-1:0]                 narrow_in_ready_o;

   logic [num_in_chan_p*wide_width_p-1:0]    wide_out_data_o;
   logic [num_in_chan_p-1:0]                 wide_out_v_o;
   logic [num_in_chan_p-1:0]                 wide_out_yumi_i;

   logic [num_out_chan_p*wide_width_p-1:0]   wide_in_data_i;
   logic [num_out_chan_p-1:0]                wide_in_v_i;
   logic [num_out_chan_p-1:0]                wide_in_ready_o;

   logic [num_out_chan_p*narrow_width_p-1:0] narrow_out_data_o;
   logic [num_out_chan_p-1:0]                narrow_out_v_o;
   logic [num_out_chan_p-1:0]                narrow_out_yumi_i;

   logic [num_out_chan_p*occ_width_lp-1:0]   out_occ_o;

   modport slave (
      input  in_clear_i, out_clear_i,
      input  narrow_in_data_i, narrow_in_v_i,
      output narrow_in_ready_o,
      output wide_out_data_o, wide_out_v_o,
      input  wide_out_yumi_i,
      input  wide_in_data_i, wide_in_v_i,
      output wide_in_ready_o,
      output narrow_out_data_o, narrow_out_v_o,
      input  narrow_out_yumi_i,
      output out_occ_o
   );

   modport master (
      output in_clear_i, out_clear_i,
      output narrow_in_data_i, narrow_in_v_i,
      input  narrow_in_ready_o,
      input  wide_out_data_o, wide_out_v_o,
      output wide_out_yumi_i,
      output wide_in_data_i, wide_in_v_i,
      input  wide_in_ready_o,
      input  narrow_out_data_o, narrow_out_v_o,
      output narrow_out_yumi_i,
      input  out_occ_o
   );

endinterface

// File: rtl/bsg_zynq_mc_gearbox_bridge_out_chan.sv
// One outbound (wide->narrow) channel: wide-entry FIFO feeding a serializer,
// plus an exact count of narrow words still pending.
// Ports:
//   clk_i, reset_i (async, active-high), clear_i (sync channel clear)
//   wide_data_i / wide_v_i / wide_ready_o     : packet enqueue
//   narrow_data_o / narrow_v_o / narrow_yumi_i: word dequeue
//   occ_o                                     : narrow words pending
// Optional: BSG_ZYNQ_GEARBOX_TRACE_EN adds load trace and protocol assertions.
module bsg_zynq_gearbox_out_chan
   import bsg_zynq_gearbox_pkg::*;
#(
   parameter int unsigned narrow_width_p = 32,
   parameter int unsigned wide_width_p   = 128,
   parameter int unsigned out_buf_els_p  = 4
)(
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    clear_i,
   input  logic [wide_width_p-1:0] wide_data_i,
   input  logic                    wide_v_i,
   output logic                    wide_ready_o,
   output logic [narrow_width_p-1:0] narrow_data_o,
   output logic                    narrow_v_o,
   input  logic                    narrow_yumi_i,
   output logic [occ_width_f(out_buf_els_p, beats_f(wide_width_p, narrow_width_p))-1:0] occ_o
);
   localparam int unsigned beats_lp     = beats_f(wide_width_p, narrow_width_p);
   localparam int unsigned occ_width_lp = occ_width_f(out_buf_els_p, beats_lp);
   localparam int unsigned cnt_width_lp = $clog2(out_buf_els_p + 1);
   localparam int unsigned ptr_width_lp = idx_width_f(out_buf_els_p);
   localparam int unsigned idx_width_lp = idx_width_f(beats_lp);

   logic [wide_width_p-1:0] r_mem [out_buf_els_p];
   logic [ptr_width_lp-1:0] r_rd_ptr, r_wr_ptr;
   logic [cnt_width_lp-1:0] r_count;
   piso_state_e             r_state, w_state_n;
   logic [idx_width_lp-1:0] r_idx, w_idx_n;
   logic [wide_width_p-1:0] r_piso;

   logic w_full, w_empty, w_enq, w_deq, w_yumi, w_last;

   function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
      return (p == ptr_width_lp'(out_buf_els_p - 1)) ? '0 : p + ptr_width_lp'(1);
   endfunction

   // Ready comes only from the registered count, never from the narrow side.
   assign w_full       = (r_count == cnt_width_lp'(out_buf_els_p));
   assign w_empty      = (r_count == '0);
   assign wide_ready_o = ~w_full;
   assign w_enq        = wide_v_i & ~w_full & ~clear_i;
   assign w_yumi       = narrow_yumi_i & (r_state == ST_BUSY);
   assign w_last       = (r_idx == idx_width_lp'(beats_lp - 1));

   // Serializer control: load head when idle, or back-to-back on last-beat yumi.
   always_comb begin
      w_state_n = r_state;
      w_idx_n   = r_idx;
      w_deq     = 1'b0;
      if (clear_i) begin
         w_state_n = ST_IDLE;
         w_idx_n   = '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (!w_empty) begin
                  w_deq     = 1'b1;
                  w_state_n = ST_BUSY;
                  w_idx_n   = '0;
               end
            end
            ST_BUSY: begin
               if (w_yumi) begin
                  if (w_last) begin
                     w_idx_n = '0;
                     if (!w_empty) begin
                        w_deq = 1'b1;
                     end else begin
                        w_state_n = ST_IDLE;
                     end
                  end else begin
                     w_idx_n = r_idx + idx_width_lp'(1);
                  end
               end
            end
            default: begin
               w_state_n = ST_IDLE;
               w_idx_n   = '0;
            end
         endcase
      end
   end

   // Serializer state register.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_state <= ST_IDLE;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_n;
         r_idx   <= w_idx_n;
      end
   end

   // FIFO pointers and entry count.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (clear_i) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_enq) r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (w_deq) r_rd_ptr <= ptr_inc(r_rd_ptr);
         case ({w_enq, w_deq})
            2'b10:   r_count <= r_count + cnt_width_lp'(1);
            2'b01:   r_count <= r_count - cnt_width_lp'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Payload storage needs no reset; validity is tracked by count/state.
   always_ff @(posedge clk_i) begin
      if (w_enq) r_mem[r_wr_ptr] <= wide_data_i;
      if (w_deq) r_piso <= r_mem[r_rd_ptr];
   end

   // Little-endian beat select.
   always_comb begin
      narrow_data_o = '0;
      for (int k = 0; k < int'(beats_lp); k++) begin
         if (r_idx == idx_width_lp'(k)) narrow_data_o = r_piso[k*narrow_width_p +: narrow_width_p];
      end
   end

   assign narrow_v_o = (r_state == ST_BUSY);

   // Pending words: whole buffered entries plus the unsent part of the serializer.
   always_comb begin
      occ_o = occ_width_lp'(r_count) * occ_width_lp'(beats_lp);
      if (r_state == ST_BUSY) occ_o = occ_o + occ_width_lp'(beats_lp) - occ_width_lp'(r_idx);
   end

`ifdef BSG_ZYNQ_GEARBOX_TRACE_EN
   logic [31:0] r_trace_cyc;
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) r_trace_cyc <= '0;
      else         r_trace_cyc <= r_trace_cyc + 32'd1;
   end

   always @(posedge clk_i) begin
      if (!reset_i) begin
         if (w_deq)
            $display("%s out-load %m cyc=%0d data=%h", trace_tag_lp, r_trace_cyc, r_mem[r_rd_ptr]);
         assert (!(narrow_yumi_i && (r_state != ST_BUSY)))
            else $error("%s %m narrow yumi without valid", trace_tag_lp);
         assert (r_count <= cnt_width_lp'(out_buf_els_p))
            else $error("%s %m buffer overflow", trace_tag_lp);
      end
   end
`endif

endmodule

// File: rtl/bsg_zynq_mc_gearbox_bridge.sv
// Multi-channel width converter between the PS narrow CSR FIFOs and the
// manycore endpoint wide packet FIFOs (manycore clock domain).
// Ports:
//   clk_i, reset_i : clock, async active-high reset
//   gb (slave)     : per-channel inbound narrow->wide and outbound wide->narrow
//                    handshakes, per-channel clears, outbound occupancy
// Optional: BSG_ZYNQ_GEARBOX_TRACE_EN adds a simulation trace of completed
// inbound words and outbound loads, plus yumi/overflow assertions.
module bsg_zynq_mc_gearbox_bridge
   import bsg_zynq_gearbox_pkg::*;
#(
   parameter int unsigned narrow_width_p = 32,
   parameter int unsigned wide_width_p   = 128,
   parameter int unsigned num_in_chan_p  = 2,
   parameter int unsigned num_out_chan_p = 2,
   parameter int unsigned out_buf_els_p  = 4
)(
   input logic                       clk_i,
   input logic                       reset_i,
   bsg_zynq_mc_gearbox_bridge_if.slave gb
);
   localparam int unsigned beats_lp     = beats_f(wide_width_p, narrow_width_p);
   localparam int unsigned occ_width_lp = occ_width_f(out_buf_els_p, beats_lp);
   localparam int unsigned cnt_width_lp = $clog2(beats_lp + 1);

   if ((wide_width_p % narrow_width_p) != 0) begin : g_width_err
      $error("wide_width_p must be a multiple of narrow_width_p");
   end
   if (out_buf_els_p < 2) begin : g_depth_err
      $error("out_buf_els_p must be at least 2");
   end

`ifdef BSG_ZYNQ_GEARBOX_TRACE_EN
   logic [31:0] r_trace_cyc;
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) r_trace_cyc <= '0;
      else         r_trace_cyc <= r_trace_cyc + 32'd1;
   end
`endif

   // Inbound SIPO per channel: cnt==beats_lp means a full word is presented.
   for (genvar c = 0; c < int'(num_in_chan_p); c++) begin : g_in
      logic [cnt_width_lp-1:0] r_cnt;
      logic [wide_width_p-1:0] r_data;
      logic                    w_ready, w_done, w_fire;

      assign w_ready = (r_cnt < cnt_width_lp'(beats_lp));
      assign w_done  = (r_cnt == cnt_width_lp'(beats_lp));
      assign w_fire  = gb.narrow_in_v_i[c] & w_ready;

      // Clear beats both the handshake and yumi; yumi cycle accepts no beat.
      always_ff @(posedge clk_i or posedge reset_i) begin
         if (reset_i)                               r_cnt <= '0;
         else if (gb.in_clear_i[c])                 r_cnt <= '0;
         else if (w_done && gb.wide_out_yumi_i[c])  r_cnt <= '0;
         else if (w_fire)                           r_cnt <= r_cnt + cnt_width_lp'(1);
      end

      always_ff @(posedge clk_i) begin
         for (int k = 0; k < int'(beats_lp); k++) begin
            if (w_fire && (r_cnt == cnt_width_lp'(k)))
               r_data[k*narrow_width_p +: narrow_width_p] <=
                  gb.narrow_in_data_i[c*narrow_width_p +: narrow_width_p];
         end
      end

      assign gb.narrow_in_ready_o[c]                           = w_ready;
      assign gb.wide_out_v_o[c]                                = w_done;
      assign gb.wide_out_data_o[c*wide_width_p +: wide_width_p] = r_data;

`ifdef BSG_ZYNQ_GEARBOX_TRACE_EN
      always @(posedge clk_i) begin
         if (!reset_i) begin
            if (w_done && gb.wide_out_yumi_i[c] && !gb.in_clear_i[c])
               $display("%s in-word ch%0d cyc=%0d data=%h", trace_tag_lp, c, r_trace_cyc, r_data);
            assert (!(gb.wide_out_yumi_i[c] && !w_done))
               else $error("%s wide yumi without valid ch%0d", trace_tag_lp, c);
         end
      end
`endif
   end

   // Outbound channels.
   for (genvar c = 0; c < int'(num_out_chan_p); c++) begin : g_out
      bsg_zynq_gearbox_out_chan #(
         .narrow_width_p (narrow_width_p),
         .wide_width_p   (wide_width_p),
         .out_buf_els_p  (out_buf_els_p)
      ) u_out_chan (
         .clk_i         (clk_i),
         .reset_i       (reset_i),
         .clear_i       (gb.out_clear_i[c]),
         .wide_data_i   (gb.wide_in_data_i[c*wide_width_p +: wide_width_p]),
         .wide_v_i      (gb.wide_in_v_i[c]),
         .wide_ready_o  (gb.wide_in_ready_o[c]),
         .narrow_data_o (gb.narrow_out_data_o[c*narrow_width_p +: narrow_width_p]),
         .narrow_v_o    (gb.narrow_out_v_o[c]),
         .narrow_yumi_i (gb.narrow_out_yumi_i[c]),
         .occ_o         (gb.out_occ_o[c*occ_width_lp +: occ_width_lp])
      );
   end

endmodule

// File: tb/tb_bsg_zynq_mc_gearbox_bridge.sv
// Directed + randomized self-checking bench for bsg_zynq_mc_gearbox_bridge.
module tb_bsg_zynq_mc_gearbox_bridge;
   import bsg_zynq_gearbox_pkg::*;

   localparam int unsigned NW    = 32;
   localparam int unsigned WW    = 128;
   localparam int unsigned NI    = 2;
   localparam int unsigned NO    = 2;
   localparam int unsigned ELS   = 4;
   localparam int unsigned BEATS = 4;
   localparam int unsigned OW    = 5;   // clog2(4*4+4+1)

   logic clk_i = 1'b0;
   logic reset_i;
   always #5 clk_i = ~clk_i;

   bsg_zynq_mc_gearbox_bridge_if #(
      .narrow_width_p(NW), .wide_width_p(WW), .num_in_chan_p(NI),
      .num_out_chan_p(NO), .out_buf_els_p(ELS)
   ) gb ();

   bsg_zynq_mc_gearbox_bridge #(
      .narrow_width_p(NW), .wide_width_p(WW), .num_in_chan_p(NI),
      .num_out_chan_p(NO), .out_buf_els_p(ELS)
   ) dut (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .gb      (gb)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s act=%h exp=%h", tag, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_inputs();
      gb.in_clear_i        = '0;
      gb.out_clear_i       = '0;
      gb.narrow_in_data_i  = '0;
      gb.narrow_in_v_i     = '0;
      gb.wide_out_yumi_i   = '0;
      gb.wide_in_data_i    = '0;
      gb.wide_in_v_i       = '0;
      gb.narrow_out_yumi_i = '0;
   endtask

   // Beat b of word j on channel ch: easy to recognise in a dump.
   function automatic logic [127:0] mkw(input int ch, input int j);
      logic [127:0] w;
      for (int b = 0; b < 4; b++)
         w[b*32 +: 32] = 32'hC0DE0000 | 32'(ch << 12) | 32'(j << 4) | 32'(b);
      return w;
   endfunction

   function automatic logic [4:0] occ(input int ch);
      return gb.out_occ_o[ch*OW +: OW];
   endfunction

   logic [127:0] w_tmp;
   logic [31:0]  in_q  [NI][$];
   logic [31:0]  out_q [NO][$];
   int           out_pops [NO];

   initial begin
      idle_inputs();
      reset_i = 1'b1;
      #22;
      // Reset state
      check_eq("rst_in_ready",  128'(gb.narrow_in_ready_o), 128'h3);
      check_eq("rst_wout_v",    128'(gb.wide_out_v_o),      128'h0);
      check_eq("rst_win_ready", 128'(gb.wide_in_ready_o),   128'h3);
      check_eq("rst_nout_v",    128'(gb.narrow_out_v_o),    128'h0);
      check_eq("rst_occ",       128'(gb.out_occ_o),         128'h0);
      cyc();
      reset_i = 1'b0;
      cyc();

      // Inbound ch0 assembly, little-endian
      gb.narrow_in_v_i[0] = 1'b1;
      gb.narrow_in_data_i[31:0] = 32'h11111111; cyc();
      gb.narrow_in_data_i[31:0] = 32'h22222222; cyc();
      gb.narrow_in_data_i[31:0] = 32'h33333333; cyc();
      gb.narrow_in_data_i[31:0] = 32'h44444444; cyc();
      check_eq("in0_v",     128'(gb.wide_out_v_o[0]), 128'h1);
      check_eq("in0_data",  gb.wide_out_data_o[127:0], 128'h44444444_33333333_22222222_11111111);
      check_eq("in0_rdy_full", 128'(gb.narrow_in_ready_o[0]), 128'h0);
      check_eq("in1_no_leak",  128'(gb.wide_out_v_o[1]), 128'h0);
      gb.narrow_in_data_i[31:0] = 32'h55555555; cyc();
      check_eq("in0_hold_v", 128'(gb.wide_out_v_o[0]), 128'h1);
      gb.wide_out_yumi_i[0] = 1'b1; cyc();
      gb.wide_out_yumi_i[0] = 1'b0;
      check_eq("in0_post_yumi_v",   128'(gb.wide_out_v_o[0]), 128'h0);
      check_eq("in0_post_yumi_rdy", 128'(gb.narrow_in_ready_o[0]), 128'h1);
      cyc();
      gb.narrow_in_data_i[31:0] = 32'h66666666; cyc();
      gb.narrow_in_data_i[31:0] = 32'h77777777; cyc();
      gb.narrow_in_data_i[31:0] = 32'h88888888; cyc();
      gb.narrow_in_v_i[0] = 1'b0;
      check_eq("in0_w2_v",    128'(gb.wide_out_v_o[0]), 128'h1);
      check_eq("in0_w2_data", gb.wide_out_data_o[127:0], 128'h88888888_77777777_66666666_55555555);
      gb.wide_out_yumi_i[0] = 1'b1; cyc();
      gb.wide_out_yumi_i[0] = 1'b0;

      // Inbound ch1 clear drops the partial word and the clear-cycle beat
      gb.narrow_in_v_i[1] = 1'b1;
      gb.narrow_in_data_i[63:32] = 32'hAAAAAAAA; cyc();
      gb.narrow_in_data_i[63:32] = 32'hBBBBBBBB; cyc();
      gb.in_clear_i[1] = 1'b1;
      gb.narrow_in_data_i[63:32] = 32'hCCCCCCCC; cyc();
      gb.in_clear_i[1] = 1'b0;
      check_eq("iclr_rdy", 128'(gb.narrow_in_ready_o[1]), 128'h1);
      check_eq("iclr_v",   128'(gb.wide_out_v_o[1]), 128'h0);
      gb.narrow_in_data_i[63:32] = 32'hD0D0D0D0; cyc();
      gb.narrow_in_data_i[63:32] = 32'hD1D1D1D1; cyc();
      gb.narrow_in_data_i[63:32] = 32'hD2D2D2D2; cyc();
      gb.narrow_in_data_i[63:32] = 32'hD3D3D3D3; cyc();
      gb.narrow_in_v_i[1] = 1'b0;
      check_eq("iclr_word_v",    128'(gb.wide_out_v_o[1]), 128'h1);
      check_eq("iclr_word_data", gb.wide_out_data_o[255:128], 128'hD3D3D3D3_D2D2D2D2_D1D1D1D1_D0D0D0D0);
      gb.wide_out_yumi_i[1] = 1'b1; cyc();
      gb.wide_out_yumi_i[1] = 1'b0;

      // Outbound ch1: fill 4 buffered + 1 serializing
      for (int j = 0; j < 5; j++) begin
         check_eq("oq_rdy_pre", 128'(gb.wide_in_ready_o[1]), 128'h1);
         gb.wide_in_v_i[1] = 1'b1;
         gb.wide_in_data_i[255:128] = mkw(1, j);
         cyc();
         if (j == 0) check_eq("oq_lat1", 128'(gb.narrow_out_v_o[1]), 128'h0);
         if (j == 1) check_eq("oq_lat2", 128'(gb.narrow_out_v_o[1]), 128'h1);
      end
      gb.wide_in_v_i[1] = 1'b0;
      check_eq("oq_full_rdy", 128'(gb.wide_in_ready_o[1]), 128'h0);
      check_eq("oq_full_occ", 128'(occ(1)), 128'd20);
      check_eq("oq_ch0_occ",  128'(occ(0)), 128'd0);
      // Drain with constant yumi; a push offered at the full/dequeue edge is refused
      gb.narrow_out_yumi_i[1] = 1'b1;
      for (int k = 0; k < 20; k++) begin
         w_tmp = mkw(1, k / 4);
         gb.wide_in_v_i[1] = (k == 3);
         gb.wide_in_data_i[255:128] = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
         if (k == 3) check_eq("oq_full_deq_rdy", 128'(gb.wide_in_ready_o[1]), 128'h0);
         check_eq("oq_drain_v",   128'(gb.narrow_out_v_o[1]), 128'h1);
         check_eq("oq_drain_d",   128'(gb.narrow_out_data_o[63:32]), 128'(w_tmp[(k%4)*32 +: 32]));
         check_eq("oq_drain_occ", 128'(occ(1)), 128'(20 - k));
         cyc();
      end
      gb.wide_in_v_i[1] = 1'b0;
      gb.narrow_out_yumi_i[1] = 1'b0;
      check_eq("oq_empty_v",   128'(gb.narrow_out_v_o[1]), 128'h0);
      check_eq("oq_empty_occ", 128'(occ(1)), 128'd0);

      // Outbound ch0 clear beats a concurrent enqueue
      gb.wide_in_v_i[0] = 1'b1;
      gb.wide_in_data_i[127:0] = mkw(0, 0); cyc();
      check_eq("oclr_pre_occ", 128'(occ(0)), 128'd4);
      gb.out_clear_i[0] = 1'b1;
      gb.wide_in_data_i[127:0] = mkw(0, 1); cyc();
      gb.out_clear_i[0] = 1'b0;
      gb.wide_in_v_i[0] = 1'b0;
      check_eq("oclr_occ", 128'(occ(0)), 128'd0);
      check_eq("oclr_v",   128'(gb.narrow_out_v_o[0]), 128'h0);
      cyc(); cyc();
      check_eq("oclr_drop_occ", 128'(occ(0)), 128'd0);
      check_eq("oclr_drop_v",   128'(gb.narrow_out_v_o[0]), 128'h0);

      // Async reset while busy with occ=6
      gb.wide_in_v_i[0] = 1'b1;
      gb.wide_in_data_i[127:0] = mkw(0, 2); cyc();
      gb.wide_in_data_i[127:0] = mkw(0, 3); cyc();
      gb.wide_in_v_i[0] = 1'b0;
      check_eq("arst_occ8", 128'(occ(0)), 128'd8);
      gb.narrow_out_yumi_i[0] = 1'b1; cyc(); cyc();
      gb.narrow_out_yumi_i[0] = 1'b0;
      check_eq("arst_occ6", 128'(occ(0)), 128'd6);
      check_eq("arst_v_pre", 128'(gb.narrow_out_v_o[0]), 128'h1);
      #2 reset_i = 1'b1;
      #1;
      check_eq("arst_occ", 128'(occ(0)), 128'd0);
      check_eq("arst_v",   128'(gb.narrow_out_v_o[0]), 128'h0);
      cyc();
      reset_i = 1'b0;
      cyc();

      // Random concurrent traffic on both channels, both directions
      for (int c = 0; c < 2; c++) out_pops[c] = 0;
      for (int t = 0; t < 800; t++) begin
         for (int c = 0; c < 2; c++) begin
            // inbound: consume completed word first, then offer a beat
            gb.wide_out_yumi_i[c] = gb.wide_out_v_o[c] && ($urandom_range(0, 2) != 0);
            if (gb.wide_out_yumi_i[c]) begin
               for (int b = 0; b < 4; b++) w_tmp[b*32 +: 32] = in_q[c].pop_front();
               check_eq("rnd_in_data", gb.wide_out_data_o[c*128 +: 128], w_tmp);
            end
            gb.narrow_in_v_i[c] = 1'($urandom_range(0, 1));
            gb.narrow_in_data_i[c*32 +: 32] = $urandom();
            if (gb.narrow_in_v_i[c] && gb.narrow_in_ready_o[c])
               in_q[c].push_back(gb.narrow_in_data_i[c*32 +: 32]);

            // outbound
            check_eq("rnd_occ", 128'(occ(c)), 128'(out_q[c].size()));
            gb.narrow_out_yumi_i[c] = gb.narrow_out_v_o[c] && ($urandom_range(0, 3) != 0);
            if (gb.narrow_out_yumi_i[c]) begin
               check_eq("rnd_out_data", 128'(gb.narrow_out_data_o[c*32 +: 32]), 128'(out_q[c].pop_front()));
               out_pops[c]++;
            end
            gb.wide_in_v_i[c] = ($urandom_range(0, 2) == 0);
            gb.wide_in_data_i[c*128 +: 128] = {$urandom(), $urandom(), $urandom(), $urandom()};
            if (gb.wide_in_v_i[c] && gb.wide_in_ready_o[c]) begin
               w_tmp = gb.wide_in_data_i[c*128 +: 128];
               for (int b = 0; b < 4; b++) out_q[c].push_back(w_tmp[b*32 +: 32]);
            end
         end
         cyc();
      end
      idle_inputs();
      check_eq("rnd_ch0_progress", 128'(out_pops[0] > 20), 128'h1);
      check_eq("rnd_ch1_progress", 128'(out_pops[1] > 20), 128'h1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
